// File: rtl/vga_fb_pixel_gen.sv
// 1-bpp framebuffer pixel generator: two-p_tick read pipeline with matched syncs,
// handshaked rasteriser write port and a clear-screen FSM. Optional macro VGA_FB_DROP_CNT_EN.
module vga_fb_pixel_gen #(
    parameter int               H_RES       = 640,
    parameter int               V_RES       = 480,
    parameter int               SCALE_SHIFT = 1,
    parameter int               RGB_W       = 12,
    parameter logic [RGB_W-1:0] FG_COLOR    = RGB_W'(12'hFFF),
    parameter logic [RGB_W-1:0] BG_COLOR    = RGB_W'(12'h000)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_p_tick,
    input  logic [9:0]       i_pixel_x,
    input  logic [9:0]       i_pixel_y,
    input  logic             i_video_on,
    input  logic             i_h_sync_in,
    input  logic             i_v_sync_in,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [9:0]       i_wr_x,
    input  logic [9:0]       i_wr_y,
    input  logic             i_wr_data,
    input  logic             i_clr_req,
    output logic             o_busy,
    output logic [RGB_W-1:0] o_rgb,
    output logic             o_h_sync_out,
    output logic             o_v_sync_out
`ifdef VGA_FB_DROP_CNT_EN
    ,
    output logic [15:0]      o_drop_count
`endif
);

    localparam int FB_W     = H_RES >> SCALE_SHIFT;
    localparam int FB_H     = V_RES >> SCALE_SHIFT;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = $clog2(FB_DEPTH);

    localparam logic [9:0]        H_LIM     = 10'(H_RES);
    localparam logic [9:0]        V_LIM     = 10'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(y >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(x >> SCALE_SHIFT);
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_addr;

    logic                w_wr_in_range;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                w_mem_data;

    logic                r_fb [0:FB_DEPTH-1];

    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_vis;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_vis_d1;
    logic                r_hs_d1;
    logic                r_vs_d1;
    logic                r_pix;
    logic                r_vis_d2;
    logic                r_hs_d2;
    logic                r_vs_d2;

    assign w_wr_in_range = (i_wr_x < H_LIM) && (i_wr_y < V_LIM);
    assign w_wr_addr     = fb_addr(i_wr_x, i_wr_y);

    // ---------------- clear FSM ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_clr_req) w_state_next = S_CLEAR;
            S_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Clear wins over a simultaneous write; out-of-range writes handshake but never reach memory.
    always_comb begin
        o_busy     = 1'b0;
        o_wr_ready = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = w_wr_addr;
        w_mem_data = i_wr_data;
        case (r_state)
            S_IDLE: begin
                o_wr_ready = ~i_clr_req & ~i_reset;
                w_mem_we   = i_wr_valid & ~i_clr_req & ~i_reset & w_wr_in_range;
            end
            S_CLEAR: begin
                o_busy     = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_addr;
                w_mem_data = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clr_addr <= '0;
        end else if (r_state == S_IDLE) begin
            r_clr_addr <= '0;
        end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // ---------------- framebuffer ----------------
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_fb[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read without reset keeps this a plain RAM output; r_vis_d2 masks it after reset.
    always_ff @(posedge i_clk) begin
        if (i_p_tick) begin
            r_pix <= r_fb[r_rd_addr];
        end
    end

    // ---------------- read pipeline ----------------
    assign w_rd_addr = fb_addr(i_pixel_x, i_pixel_y);
    assign w_vis     = i_video_on && (i_pixel_x < H_LIM) && (i_pixel_y < V_LIM);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_addr <= '0;
            r_vis_d1  <= 1'b0;
            r_hs_d1   <= 1'b0;
            r_vs_d1   <= 1'b0;
            r_vis_d2  <= 1'b0;
            r_hs_d2   <= 1'b0;
            r_vs_d2   <= 1'b0;
        end else if (i_p_tick) begin
            r_rd_addr <= w_rd_addr;
            r_vis_d1  <= w_vis;
            r_hs_d1   <= i_h_sync_in;
            r_vs_d1   <= i_v_sync_in;
            r_vis_d2  <= r_vis_d1;
            r_hs_d2   <= r_hs_d1;
            r_vs_d2   <= r_vs_d1;
        end
    end

    assign o_rgb        = r_vis_d2 ? (r_pix ? FG_COLOR : BG_COLOR) : '0;
    assign o_h_sync_out = r_hs_d2;
    assign o_v_sync_out = r_vs_d2;

`ifdef VGA_FB_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = i_wr_valid & o_wr_ready & ~w_wr_in_range;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_count = r_drop_cnt;
`endif

endmodule
